// File: rtl/multiboot_pkg.sv
// Shared ICAP command words, sequencer state encoding and WBSTAR encoder
// for the multiboot warm-reboot sequencer.
package multiboot_pkg;

    localparam logic [31:0] ICAP_DUMMY      = 32'hFFFF_FFFF;
    localparam logic [31:0] ICAP_SYNC       = 32'hAA99_5566;
    localparam logic [31:0] ICAP_NOP        = 32'h2000_0000;
    localparam logic [31:0] ICAP_WBSTAR_HDR = 32'h3002_0001;
    localparam logic [31:0] ICAP_CMD_HDR    = 32'h3000_8001;
    localparam logic [31:0] ICAP_IPROG_CMD  = 32'h0000_000F;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DUMMY,
        ST_SYNC,
        ST_NOP0,
        ST_WB_HDR,
        ST_WB_VAL,
        ST_CMD_HDR,
        ST_IPROG,
        ST_TAIL,
        ST_FIN
    } state_e;

    // 32-bit SPI mode drops the low byte; 24-bit mode keeps 29 address bits
    function automatic logic [31:0] wbstar_enc(input logic [31:0] addr,
                                               input logic        spi32);
        if (spi32) begin
            return {8'h00, addr[31:8]};
        end
        return {3'b000, addr[28:0]};
    endfunction

endpackage

// File: rtl/multiboot_addr_sel.sv
// Boot address selection: slot/override mux, slot range check and
// WBSTAR encoding. Purely combinational.
module multiboot_addr_sel
    import multiboot_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned SLOT_W      = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] SLOT_STRIDE = 32'h0040_0000,
    parameter bit          SPI_32BIT   = 1'b0
) (
    input  logic [SLOT_W-1:0] slot_i,
    input  logic              addr_ovr_en_i,
    input  logic [31:0]       addr_ovr_i,
    output logic              valid_o,
    output logic [31:0]       wbstar_o
);

    logic [31:0] slot_ext;
    logic [31:0] slot_addr;
    logic [31:0] addr;

    assign slot_ext  = 32'(slot_i);
    // Wraps modulo 2^32 by construction of the 32-bit datapath
    assign slot_addr = BASE_ADDR + slot_ext * SLOT_STRIDE;
    assign addr      = addr_ovr_en_i ? addr_ovr_i : slot_addr;
    assign valid_o   = addr_ovr_en_i || (slot_ext < NUM_SLOTS);
    assign wbstar_o  = wbstar_enc(addr, SPI_32BIT);

endmodule

// File: rtl/multiboot_icap_seq.sv
// Warm-reboot sequencer: streams the IPROG command sequence to an
// ICAPE2 wrapper with a run-time selected WBSTAR boot address.
module multiboot_icap_seq
    import multiboot_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned SLOT_W      = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] SLOT_STRIDE = 32'h0040_0000,
    parameter bit          SPI_32BIT   = 1'b0,
    parameter int unsigned TAIL_NOPS   = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [SLOT_W-1:0] slot,
    input  logic              addr_ovr_en,
    input  logic [31:0]       addr_ovr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              icap_ce,
    output logic              icap_we,
    output logic [31:0]       icap_data
);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] wbstar_q, wbstar_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ce_q, ce_d;
    logic        we_q, we_d;
    logic [31:0] data_q, data_d;

    logic        sel_valid;
    logic [31:0] sel_wbstar;

    multiboot_addr_sel #(
        .NUM_SLOTS   (NUM_SLOTS),
        .SLOT_W      (SLOT_W),
        .BASE_ADDR   (BASE_ADDR),
        .SLOT_STRIDE (SLOT_STRIDE),
        .SPI_32BIT   (SPI_32BIT)
    ) u_addr_sel (
        .slot_i        (slot),
        .addr_ovr_en_i (addr_ovr_en),
        .addr_ovr_i    (addr_ovr),
        .valid_o       (sel_valid),
        .wbstar_o      (sel_wbstar)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wbstar_d = wbstar_q;
        err_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (sel_valid) begin
                        wbstar_d = sel_wbstar;
                        state_d  = ST_DUMMY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DUMMY:   state_d = ST_SYNC;
            ST_SYNC:    state_d = ST_NOP0;
            ST_NOP0:    state_d = ST_WB_HDR;
            ST_WB_HDR:  state_d = ST_WB_VAL;
            ST_WB_VAL:  state_d = ST_CMD_HDR;
            ST_CMD_HDR: state_d = ST_IPROG;
            ST_IPROG: begin
                state_d = ST_TAIL;
                cnt_d   = 8'(TAIL_NOPS - 1);
            end
            ST_TAIL: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_FIN:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output word is decoded from the next state so it is registered
    // and visible during that state's own cycle
    always_comb begin
        ce_d   = 1'b0;
        we_d   = 1'b0;
        data_d = ICAP_DUMMY;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
        unique case (state_d)
            ST_SYNC:    data_d = ICAP_SYNC;
            ST_NOP0:    data_d = ICAP_NOP;
            ST_WB_HDR:  data_d = ICAP_WBSTAR_HDR;
            ST_WB_VAL:  data_d = wbstar_q;
            ST_CMD_HDR: data_d = ICAP_CMD_HDR;
            ST_IPROG:   data_d = ICAP_IPROG_CMD;
            ST_TAIL:    data_d = ICAP_NOP;
            default:    data_d = ICAP_DUMMY;
        endcase
        if (state_d inside {ST_SYNC, ST_NOP0, ST_WB_HDR, ST_WB_VAL,
                            ST_CMD_HDR, ST_IPROG, ST_TAIL}) begin
            ce_d = 1'b1;
            we_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            wbstar_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ce_q     <= 1'b0;
            we_q     <= 1'b0;
            data_q   <= ICAP_DUMMY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wbstar_q <= wbstar_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ce_q     <= ce_d;
            we_q     <= we_d;
            data_q   <= data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign icap_ce   = ce_q;
    assign icap_we   = we_q;
    assign icap_data = data_q;

endmodule

// File: tb/tb_multiboot_icap_seq.sv
// Bench for multiboot_icap_seq: three parameter sets checked against
// a sequence-table reference model.
module tb_multiboot_icap_seq;

    localparam int unsigned NS[3]     = '{4, 4, 3};
    localparam logic [31:0] BASE[3]   = '{32'h0, 32'h0, 32'hFFC0_0000};
    localparam logic [31:0] STRIDE[3] = '{32'h40_0000, 32'h40_0000, 32'h40_0000};
    localparam bit          SPI[3]    = '{1'b0, 1'b1, 1'b0};
    localparam int          TN[3]     = '{9, 9, 1};

    localparam logic [36:0] IDLE_W = {5'b00000, 32'hFFFF_FFFF};

    logic        clk;
    logic        rst_n;
    logic        req[3];
    logic [1:0]  slt[3];
    logic        aoe[3];
    logic [31:0] aov[3];
    logic        busy[3];
    logic        done[3];
    logic        err[3];
    logic        ce[3];
    logic        we[3];
    logic [31:0] dat[3];

    int n_chk = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multiboot_icap_seq #(
        .NUM_SLOTS(4), .SLOT_W(2), .BASE_ADDR(32'h0),
        .SLOT_STRIDE(32'h40_0000), .SPI_32BIT(1'b0), .TAIL_NOPS(9)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .slot(slt[0]),
        .addr_ovr_en(aoe[0]), .addr_ovr(aov[0]), .busy(busy[0]),
        .done(done[0]), .err(err[0]), .icap_ce(ce[0]),
        .icap_we(we[0]), .icap_data(dat[0])
    );

    multiboot_icap_seq #(
        .NUM_SLOTS(4), .SLOT_W(2), .BASE_ADDR(32'h0),
        .SLOT_STRIDE(32'h40_0000), .SPI_32BIT(1'b1), .TAIL_NOPS(9)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .slot(slt[1]),
        .addr_ovr_en(aoe[1]), .addr_ovr(aov[1]), .busy(busy[1]),
        .done(done[1]), .err(err[1]), .icap_ce(ce[1]),
        .icap_we(we[1]), .icap_data(dat[1])
    );

    multiboot_icap_seq #(
        .NUM_SLOTS(3), .SLOT_W(2), .BASE_ADDR(32'hFFC0_0000),
        .SLOT_STRIDE(32'h40_0000), .SPI_32BIT(1'b0), .TAIL_NOPS(1)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .req(req[2]), .slot(slt[2]),
        .addr_ovr_en(aoe[2]), .addr_ovr(aov[2]), .busy(busy[2]),
        .done(done[2]), .err(err[2]), .icap_ce(ce[2]),
        .icap_we(we[2]), .icap_data(dat[2])
    );

    function automatic logic [36:0] obs(input int k);
        return {busy[k], done[k], err[k], ce[k], we[k], dat[k]};
    endfunction

    task automatic chk(input string tag, input logic [36:0] o,
                       input logic [36:0] e);
        n_chk++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Reference: boot address from the slot/override rules, then WBSTAR
    function automatic logic [31:0] exp_wbstar(input int k,
                                               input logic oen,
                                               input logic [31:0] ov,
                                               input logic [1:0] sl,
                                               output bit ok);
        longint unsigned a;
        ok = 1'b1;
        if (oen) begin
            a = longint'(ov);
        end else if (int'(sl) < int'(NS[k])) begin
            a = (longint'(BASE[k]) + longint'(sl) * longint'(STRIDE[k]))
                % 64'h1_0000_0000;
        end else begin
            ok = 1'b0;
            a  = 0;
        end
        if (SPI[k]) return 32'(a / 256);
        return 32'(a % (64'd1 << 29));
    endfunction

    // Expected {busy,done,err,ce,we,data} p+1 cycles after acceptance
    function automatic logic [36:0] seq_word(input int k, input int p,
                                             input logic [31:0] wb);
        if (p == 0) return {5'b10000, 32'hFFFF_FFFF};
        if (p == 1) return {5'b10011, 32'hAA99_5566};
        if (p == 2) return {5'b10011, 32'h2000_0000};
        if (p == 3) return {5'b10011, 32'h3002_0001};
        if (p == 4) return {5'b10011, wb};
        if (p == 5) return {5'b10011, 32'h3000_8001};
        if (p == 6) return {5'b10011, 32'h0000_000F};
        if (p < 7 + TN[k]) return {5'b10011, 32'h2000_0000};
        if (p == 7 + TN[k]) return {5'b11000, 32'hFFFF_FFFF};
        return IDLE_W;
    endfunction

    task automatic do_req(input int k, input logic oen,
                          input logic [31:0] ov, input logic [1:0] sl,
                          input string tag);
        bit ok;
        logic [31:0] wb;
        wb = exp_wbstar(k, oen, ov, sl, ok);
        @(negedge clk);
        req[k] = 1'b1;
        aoe[k] = oen;
        aov[k] = ov;
        slt[k] = sl;
        @(negedge clk);
        req[k] = 1'b0;
        aoe[k] = 1'($urandom);
        aov[k] = $urandom;
        slt[k] = 2'($urandom);
        if (!ok) begin
            chk($sformatf("%s err", tag), obs(k), {5'b00100, 32'hFFFF_FFFF});
            @(negedge clk);
            chk($sformatf("%s err_idle", tag), obs(k), IDLE_W);
            return;
        end
        for (int p = 0; p <= 8 + TN[k]; p++) begin
            chk($sformatf("%s p%0d", tag, p), obs(k), seq_word(k, p, wb));
            req[k] = (p < 7 + TN[k]) ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        bit ok;
        logic [31:0] wb;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0;
            slt[k] = 2'd0;
            aoe[k] = 1'b0;
            aov[k] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("reset%0d", k), obs(k), IDLE_W);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("idle%0d", k), obs(k), IDLE_W);

        do_req(0, 1'b0, 32'h0, 2'd2, "slot2");
        do_req(1, 1'b1, 32'h0123_4567, 2'd0, "ovr32");
        do_req(2, 1'b0, 32'h0, 2'd3, "badslot");
        do_req(2, 1'b0, 32'h0, 2'd1, "wrap");
        do_req(0, 1'b1, 32'hFFFF_FFFF, 2'd3, "ovr24max");

        // Asynchronous reset in the middle of TAIL
        @(negedge clk);
        req[0] = 1'b1;
        slt[0] = 2'd1;
        aoe[0] = 1'b0;
        @(negedge clk);
        req[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_tail", obs(0), {5'b10011, 32'h2000_0000});
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("async_rst%0d", k), obs(k), IDLE_W);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst", obs(0), IDLE_W);
        do_req(0, 1'b0, 32'h0, 2'd3, "restart");

        // req held high: back-to-back sequences separated by FIN + IDLE
        wb = exp_wbstar(2, 1'b0, 32'h0, 2'd1, ok);
        @(negedge clk);
        req[2] = 1'b1;
        aoe[2] = 1'b0;
        slt[2] = 2'd1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            chk($sformatf("held c%0d", c), obs(2),
                seq_word(2, (c - 1) % (9 + TN[2]), wb));
        end
        req[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_end", obs(2), IDLE_W);

        for (int i = 0; i < 20; i++) begin
            int k;
            k = int'($urandom_range(0, 2));
            do_req(k, 1'($urandom_range(0, 3) == 0), $urandom,
                   2'($urandom), $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multiboot_icap_seq.md
Name: multiboot_icap_seq

Overview:
- Parametrised successor to the fixed-address Artix-7 warm-reboot sequencer.
- On request, streams the UG470 IPROG command sequence to an ICAPE2 wrapper. The warm-boot start address is computed at run time, either from a slot index or from an explicit override.
- Adds request/busy/done handshake, invalid-slot error, SPI 24/32-bit address modes, configurable tail NOPs and an asynchronous reset.
- Sits between user reboot logic and the existing bit-swapping ICAPE2 wrapper. Outputs are active-high ce/we; the wrapper inverts them.

Parameters:
- NUM_SLOTS, 4: number of bitstream slots; slot indices 0..NUM_SLOTS-1 are valid.
- SLOT_W, 2: width of the slot port; must be at least clog2(NUM_SLOTS), minimum 1.
- BASE_ADDR, 32'h0000_0000: flash byte address of slot 0.
- SLOT_STRIDE, 32'h0040_0000: flash byte distance between consecutive slots.
- SPI_32BIT, 0: 0 = 24-bit SPI addressing, 1 = 32-bit SPI addressing. Affects WBSTAR encoding only.
- TAIL_NOPS, 9: number of NOP words after IPROG; range 1..255.

Ports:
- clk  in  1  system clock, also clocks ICAPE2; at most 20 MHz.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  reboot request, level-sampled in IDLE only.
- slot  in  SLOT_W  slot index, sampled with req.
- addr_ovr_en  in  1  when 1, use addr_ovr instead of slot; sampled with req.
- addr_ovr  in  32  explicit flash byte address.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse after the last word has been issued.
- err  out  1  one-cycle pulse when a request is rejected.
- icap_ce  out  1  ICAP chip enable, active high.
- icap_we  out  1  ICAP write enable, active high.
- icap_data  out  32  ICAP word, natural bit order; swapping is done in the wrapper.

Behaviour:
- Reset (async, rst_n=0) and idle output values:
  - busy=0, done=0, err=0, icap_ce=0, icap_we=0, icap_data=32'hFFFF_FFFF.
  - state=IDLE.
  - Reset asserted mid-sequence aborts immediately to these values. No partial word is held.
- States: IDLE, DUMMY, SYNC, NOP0, WB_HDR, WB_VAL, CMD_HDR, IPROG, TAIL, FIN.
  - Each state lasts exactly one clk, except TAIL, which lasts TAIL_NOPS clks.
- Request acceptance: in IDLE with req=1 at edge t:
  - Address selection:
    - if addr_ovr_en=1: addr = addr_ovr;
    - else if slot < NUM_SLOTS: addr = BASE_ADDR + slot*SLOT_STRIDE, computed mod 2^32;
    - else: reject. err=1 at t+1, stay in IDLE, no ICAP activity.
  - On accept, latch the WBSTAR value and go to DUMMY.
  - busy=1 from t+1 through the FIN cycle inclusive.
- WBSTAR encoding:
  - SPI_32BIT=0: {3'b000, addr[28:0]}.
  - SPI_32BIT=1: {8'h00, addr[31:8]}; addr[7:0] are ignored. Images need a 256-byte dummy pad.
- Output word per state, registered and visible during that state's cycle, as {ce, we, data}:
  - DUMMY: {0, 0, FFFFFFFF}
  - SYNC: {1, 1, AA995566}
  - NOP0: {1, 1, 20000000}
  - WB_HDR: {1, 1, 30020001}
  - WB_VAL: {1, 1, wbstar}
  - CMD_HDR: {1, 1, 30008001}
  - IPROG: {1, 1, 0000000F}
  - TAIL: {1, 1, 20000000}, repeated TAIL_NOPS times, counted by an 8-bit down-counter.
  - FIN: idle values; done=1 for this one cycle, then go to IDLE.
- Timing:
  - SYNC appears at t+2; IPROG at t+7.
  - Total active words = 6 + TAIL_NOPS; FIN occurs at t+8+TAIL_NOPS.
- req asserted while busy is ignored; no queueing. A req held high through FIN starts a new sequence from IDLE on the next edge.
- slot, addr_ovr_en and addr_ovr may change freely after acceptance; the latched WBSTAR value is used.
- On silicon the device reconfigures during TAIL; the remaining states exist for simulation and for devices that ignore IPROG.

Decomposition:
- Package multiboot_pkg:
  - ICAP command constants: DUMMY, SYNC, NOP, WBSTAR_HDR, CMD_HDR, IPROG_CMD.
  - State enum.
  - Function wbstar_enc(addr, spi32).
- One natural sub-module, multiboot_addr_sel: combinational slot/override mux, range check and WBSTAR encoding. The top level keeps the FSM, tail counter and output registers.
- The ICAPE2 wrapper is unchanged and instantiated by the integrator.

Test Plan:
- Default params, slot=2, req pulse at t → WB_VAL word = 0x00800000 at t+5; IPROG 0x0000000F at t+7; 9 NOPs; done at t+17; busy high t+1..t+17.
- SPI_32BIT=1, addr_ovr_en=1, addr_ovr=0x01234567 → WB_VAL = 0x00012345; all other words identical to the first test.
- NUM_SLOTS=3, SLOT_W=2, slot=3 → err pulse at t+1; busy, ce and we stay 0; icap_data stays 0xFFFFFFFF.
- rst_n=0 during the TAIL state → all outputs return to idle values asynchronously (within the same cycle); after release, a new req restarts at DUMMY.
- req held high for 40 cycles, TAIL_NOPS=1 → back-to-back sequences with FIN then IDLE (2 cycles) between them; req pulses inside busy produce no extra sequence.
- BASE_ADDR=0xFFC00000, slot=1 → wraps to addr=0x00000000; WB_VAL=0x00000000 with SPI_32BIT=0.
